// File: rtl/dual_issue_scheduler_pkg.sv
// Shared types and helpers for the dual-issue scheduler.
// The instruction record layout is {pc, ctl_t}. ctl_t holds every field
// the pairing logic inspects, so pc always sits directly above it.
package dual_issue_pkg;

    localparam int REG_W    = 5;
    localparam int CTL_W    = 3 * REG_W + 4;   // rs, rt, dest, 4 flag bits
    localparam int PC_LSB   = CTL_W;
    localparam int PC_W_DEF = 32;
    localparam int INFO_W   = PC_W_DEF + CTL_W;

    // Low part of a record, MSB to LSB.
    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dest;
        logic             regwrite;
        logic             is_load;
        logic             is_mem;
        logic             is_branch;
    } ctl_t;

    // A load in EX cannot forward to an instruction that issues now if it
    // reads the load's destination. r0 is never a real dependency.
    function automatic logic loaduse(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             ex_load1,
        input logic [REG_W-1:0] ex_dest1,
        input logic             ex_load2,
        input logic [REG_W-1:0] ex_dest2
    );
        return (ex_load1 && ex_dest1 != '0 && (ex_dest1 == rs || ex_dest1 == rt)) ||
               (ex_load2 && ex_dest2 != '0 && (ex_dest2 == rs || ex_dest2 == rt));
    endfunction

endpackage

// File: rtl/dual_issue_scheduler_if.sv
// Decode, EX-hazard and issue signals of the dual-issue scheduler.
// slave is the scheduler side; master is the pipeline surrounding it.
interface dual_issue_if
    import dual_issue_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int INFO_W = PC_W + CTL_W
);
    logic              flush;
    logic              stall;
    logic              in_valid0;
    logic              in_valid1;
    logic [INFO_W-1:0] in_info0;
    logic [INFO_W-1:0] in_info1;
    logic              in_ready;
    logic              ex_load1;
    logic              ex_load2;
    logic [REG_W-1:0]  ex_dest1;
    logic [REG_W-1:0]  ex_dest2;
    logic              iss_valid0;
    logic              iss_valid1;
    logic [INFO_W-1:0] iss_info0;
    logic [INFO_W-1:0] iss_info1;

    modport slave (
        input  flush, stall, in_valid0, in_valid1, in_info0, in_info1,
               ex_load1, ex_load2, ex_dest1, ex_dest2,
        output in_ready, iss_valid0, iss_valid1, iss_info0, iss_info1
    );

    modport master (
        output flush, stall, in_valid0, in_valid1, in_info0, in_info1,
               ex_load1, ex_load2, ex_dest1, ex_dest2,
        input  in_ready, iss_valid0, iss_valid1, iss_info0, iss_info1
    );
endinterface

// File: rtl/dual_issue_scheduler_pair_check.sv
// Combinational issue decision for the two oldest buffered instructions.
// H0 may go alone; H1 only goes alongside H0 when the forwarding network
// can resolve everything between them.
module pair_check
    import dual_issue_pkg::*;
(
    input  logic             i_en,
    input  logic             i_h0_vld,
    input  logic             i_h1_vld,
    input  ctl_t             i_h0,
    input  ctl_t             i_h1,
    input  logic             i_ex_load1,
    input  logic [REG_W-1:0] i_ex_dest1,
    input  logic             i_ex_load2,
    input  logic [REG_W-1:0] i_ex_dest2,
    output logic             o_go0,
    output logic             o_go1
);
    logic w_lu0, w_lu1, w_raw, w_waw, w_mem2, w_unused;

    assign w_lu0 = loaduse(i_h0.rs, i_h0.rt, i_ex_load1, i_ex_dest1, i_ex_load2, i_ex_dest2);
    assign w_lu1 = loaduse(i_h1.rs, i_h1.rt, i_ex_load1, i_ex_dest1, i_ex_load2, i_ex_dest2);

    // H1 would read H0's result in the same EX cycle: nothing to forward from.
    assign w_raw  = i_h0.regwrite && i_h0.dest != '0 &&
                    (i_h0.dest == i_h1.rs || i_h0.dest == i_h1.rt);
    assign w_waw  = i_h0.regwrite && i_h1.regwrite && i_h0.dest == i_h1.dest;
    // Only one memory port downstream.
    assign w_mem2 = i_h0.is_mem && i_h1.is_mem;

    assign o_go0 = i_en && i_h0_vld && !w_lu0;
    // A branch at H0 goes alone so nothing younger slips past a redirect.
    assign o_go1 = o_go0 && i_h1_vld && !w_lu1 && !w_raw && !w_waw &&
                   !w_mem2 && !i_h0.is_branch;

    // Fields carried in the record but not needed for pairing.
    assign w_unused = ^{i_h0.is_load, i_h1.is_load, i_h1.is_branch};
endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order issue buffer between decode and ID/EX. Holds up to DEPTH
// records in a circular buffer and issues 0, 1 or 2 of the oldest per
// cycle through registered issue slots. DEPTH must be a power of 2, >= 4.
module dual_issue_scheduler
    import dual_issue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INFO_W = PC_W + CTL_W
)(
    input logic        clk,
    input logic        rst,
    dual_issue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    logic [INFO_W-1:0] r_buf [DEPTH];
    logic [PTR_W-1:0]  r_head, r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_iss_valid0, r_iss_valid1;
    logic [INFO_W-1:0] r_iss_info0, r_iss_info1;

    logic              w_in_ready, w_enq0, w_enq1, w_go0, w_go1;
    logic [PTR_W-1:0]  w_head1, w_tail1;
    logic [CNT_W-1:0]  w_enq_n, w_deq_n;
    logic [INFO_W-1:0] w_h0, w_h1;

    // Room for a whole pair is required, so decode never has to split one.
    assign w_in_ready = r_count <= READY_MAX;
    assign w_enq0     = w_in_ready && bus.in_valid0 && !bus.flush;
    assign w_enq1     = w_enq0 && bus.in_valid1;
    assign w_enq_n    = CNT_W'(w_enq0) + CNT_W'(w_enq1);
    assign w_deq_n    = CNT_W'(w_go0) + CNT_W'(w_go1);

    assign w_head1 = r_head + PTR_W'(1);
    assign w_tail1 = r_tail + PTR_W'(1);
    // Entries past count are stale; pair_check masks them via the vld inputs.
    assign w_h0    = r_buf[r_head];
    assign w_h1    = r_buf[w_head1];

    pair_check u_pair_check (
        .i_en       (!bus.stall && !bus.flush),
        .i_h0_vld   (r_count != '0),
        .i_h1_vld   (r_count >= CNT_W'(2)),
        .i_h0       (ctl_t'(w_h0[CTL_W-1:0])),
        .i_h1       (ctl_t'(w_h1[CTL_W-1:0])),
        .i_ex_load1 (bus.ex_load1),
        .i_ex_dest1 (bus.ex_dest1),
        .i_ex_load2 (bus.ex_load2),
        .i_ex_dest2 (bus.ex_dest2),
        .o_go0      (w_go0),
        .o_go1      (w_go1)
    );

    // Record storage; writes only land in free slots since enqueue needs
    // two free entries, so same-cycle dequeue reads are never disturbed.
    always_ff @(posedge clk) begin
        if (w_enq0) r_buf[r_tail]  <= bus.in_info0;
        if (w_enq1) r_buf[w_tail1] <= bus.in_info1;
    end

    // Pointers and occupancy; flush empties the buffer and rebases to 0.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + w_enq_n[PTR_W-1:0];
            r_head  <= r_head + w_deq_n[PTR_W-1:0];
            r_count <= r_count + w_enq_n - w_deq_n;
        end
    end

    // Issue slots: load the heads unless downstream is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_valid0 <= 1'b0;
            r_iss_valid1 <= 1'b0;
            r_iss_info0  <= '0;
            r_iss_info1  <= '0;
        end else if (bus.flush) begin
            r_iss_valid0 <= 1'b0;
            r_iss_valid1 <= 1'b0;
        end else if (!bus.stall) begin
            r_iss_valid0 <= w_go0;
            r_iss_valid1 <= w_go1;
            r_iss_info0  <= w_h0;
            r_iss_info1  <= w_h1;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.iss_valid0 = r_iss_valid0;
    assign bus.iss_valid1 = r_iss_valid1;
    assign bus.iss_info0  = r_iss_info0;
    assign bus.iss_info1  = r_iss_info1;
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed table-driven bench for dual_issue_scheduler plus hand-written
// reset sequences. Each table row is one cycle: inputs driven after the
// falling edge, in_ready checked before the rising edge, iss_* after it.
module tb_dual_issue_scheduler;
    import dual_issue_pkg::*;

    localparam int PC_W = 32;
    localparam int IW   = PC_W + CTL_W;

    typedef struct {
        logic          fl, st, v0, v1;
        logic [IW-1:0] i0, i1;
        logic [11:0]   ex;        // {load1, dest1, load2, dest2}
        logic          rdy, iv0, iv1;
        logic [31:0]   pc0, pc1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vq[$];

    dual_issue_if #(.PC_W(PC_W)) bus ();

    dual_issue_scheduler #(.DEPTH(4), .PC_W(PC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mk(input logic [31:0] pc, input int rs, input int rt,
                                         input int dest, input logic rw, input logic ld,
                                         input logic mem, input logic br);
        return {pc, 5'(rs), 5'(rt), 5'(dest), rw, ld, mem, br};
    endfunction

    function automatic vec_t mkv(input logic fl, input logic st, input logic v0, input logic v1,
                                 input logic [IW-1:0] i0, input logic [IW-1:0] i1,
                                 input logic [11:0] ex, input logic rdy, input logic iv0,
                                 input logic iv1, input logic [31:0] pc0, input logic [31:0] pc1);
        vec_t v;
        v.fl = fl; v.st = st; v.v0 = v0; v.v1 = v1; v.i0 = i0; v.i1 = i1; v.ex = ex;
        v.rdy = rdy; v.iv0 = iv0; v.iv1 = iv1; v.pc0 = pc0; v.pc1 = pc1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic st, input logic v0, input logic v1,
                         input logic [IW-1:0] i0, input logic [IW-1:0] i1, input logic [11:0] ex);
        bus.flush     = fl;
        bus.stall     = st;
        bus.in_valid0 = v0;
        bus.in_valid1 = v1;
        bus.in_info0  = i0;
        bus.in_info1  = i1;
        bus.ex_load1  = ex[11];
        bus.ex_dest1  = ex[10:6];
        bus.ex_load2  = ex[5];
        bus.ex_dest2  = ex[4:0];
    endtask

    // Structural invariant, checked every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) chk("inv_valid1_without_valid0", 64'(bus.iss_valid1 && !bus.iss_valid0), 64'(0));
    end

    initial begin
        logic [IW-1:0] N, A, B, C, D, E, F, P0, P1, P2, P3, X0, X1, L0, L1;
        logic [IW-1:0] BQ, AQ, M0, M1, W0, W1, Q0, Q1, Q2, Z0, Z1, K0, K1, K2, K3;
        N  = '0;
        A  = mk(32'h100, 3, 4, 1, 1, 0, 0, 0);
        B  = mk(32'h104, 3, 4, 2, 1, 0, 0, 0);
        C  = mk(32'h108, 1, 2, 5, 1, 0, 0, 0);
        D  = mk(32'h10c, 5, 0, 6, 1, 0, 0, 0);
        E  = mk(32'h110, 7, 0, 8, 1, 0, 0, 0);
        F  = mk(32'h114, 9, 0, 10, 1, 0, 0, 0);
        P0 = mk(32'h200, 3, 4, 11, 1, 0, 0, 0);
        P1 = mk(32'h204, 3, 4, 12, 1, 0, 0, 0);
        P2 = mk(32'h208, 3, 4, 13, 1, 0, 0, 0);
        P3 = mk(32'h20c, 3, 4, 14, 1, 0, 0, 0);
        X0 = mk(32'h300, 3, 4, 15, 1, 0, 0, 0);
        X1 = mk(32'h304, 3, 4, 16, 1, 0, 0, 0);
        L0 = mk(32'h400, 3, 0, 17, 1, 1, 1, 0);
        L1 = mk(32'h404, 4, 0, 18, 1, 1, 1, 0);
        BQ = mk(32'h500, 3, 4, 0, 0, 0, 0, 1);
        AQ = mk(32'h504, 3, 4, 19, 1, 0, 0, 0);
        M0 = mk(32'h600, 3, 4, 20, 1, 0, 0, 0);
        M1 = mk(32'h604, 3, 4, 0, 0, 0, 0, 1);
        W0 = mk(32'h700, 3, 4, 21, 1, 0, 0, 0);
        W1 = mk(32'h704, 4, 3, 21, 1, 0, 0, 0);
        Q0 = mk(32'h800, 3, 4, 22, 1, 0, 0, 0);
        Q1 = mk(32'h804, 3, 4, 23, 1, 0, 0, 0);
        Q2 = mk(32'h808, 3, 4, 24, 1, 0, 0, 0);
        Z0 = mk(32'h900, 3, 4, 25, 1, 0, 0, 0);
        Z1 = mk(32'h904, 3, 4, 26, 1, 0, 0, 0);
        K0 = mk(32'hb00, 3, 4, 27, 1, 0, 0, 0);
        K1 = mk(32'hb04, 3, 4, 28, 1, 0, 0, 0);
        K2 = mk(32'hb08, 3, 4, 29, 1, 0, 0, 0);
        K3 = mk(32'hb0c, 3, 4, 30, 1, 0, 0, 0);

        //            fl st v0 v1 i0  i1  ex               rdy iv0 iv1 pc0      pc1
        vq.push_back(mkv(0, 0, 1, 1, A,  B,  12'h000,          1, 0, 0, 0,       0));       // independent pair in
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  12'h000,          1, 1, 1, 32'h100, 32'h104)); // both issue
        vq.push_back(mkv(0, 0, 1, 1, C,  D,  12'h000,          1, 0, 0, 0,       0));       // RAW pair in
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  12'h000,          1, 1, 0, 32'h108, 0));       // older alone
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  12'h000,          1, 1, 0, 32'h10c, 0));       // younger next
        vq.push_back(mkv(0, 0, 1, 0, E,  N,  {1'b1, 5'd7, 6'd0}, 1, 0, 0, 0,     0));       // reads r7
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  {1'b1, 5'd7, 6'd0}, 1, 0, 0, 0,     0));       // load-use pipe 1
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  12'h000,          1, 1, 0, 32'h110, 0));       // hazard gone
        vq.push_back(mkv(0, 0, 1, 0, F,  N,  12'h000,          1, 0, 0, 0,       0));       // reads r9
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  {6'd0, 1'b1, 5'd9}, 1, 0, 0, 0,     0));       // load-use pipe 2
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  {6'd0, 1'b1, 5'd0}, 1, 1, 0, 32'h114, 0));     // r0 load no hazard
        vq.push_back(mkv(0, 1, 1, 1, P0, P1, 12'h000,          1, 1, 0, 32'h114, 0));       // stall holds, fill
        vq.push_back(mkv(0, 1, 1, 1, P2, P3, 12'h000,          1, 1, 0, 32'h114, 0));       // fill to 4, wraps
        vq.push_back(mkv(0, 1, 1, 1, X0, X1, 12'h000,          0, 1, 0, 32'h114, 0));       // full: ignored
        vq.push_back(mkv(0, 0, 1, 1, X0, X1, 12'h000,          0, 1, 1, 32'h200, 32'h204)); // release
        vq.push_back(mkv(0, 0, 1, 1, X0, X1, 12'h000,          1, 1, 1, 32'h208, 32'h20c)); // enq+deq
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  12'h000,          1, 1, 1, 32'h300, 32'h304)); // held pair arrives
        vq.push_back(mkv(0, 0, 1, 1, L0, L1, 12'h000,          1, 0, 0, 0,       0));       // two loads
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  12'h000,          1, 1, 0, 32'h400, 0));
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  12'h000,          1, 1, 0, 32'h404, 0));
        vq.push_back(mkv(0, 0, 1, 1, BQ, AQ, 12'h000,          1, 0, 0, 0,       0));       // branch at H0
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  12'h000,          1, 1, 0, 32'h500, 0));
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  12'h000,          1, 1, 0, 32'h504, 0));
        vq.push_back(mkv(0, 0, 1, 1, M0, M1, 12'h000,          1, 0, 0, 0,       0));       // branch at H1
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  12'h000,          1, 1, 1, 32'h600, 32'h604));
        vq.push_back(mkv(0, 0, 1, 1, W0, W1, 12'h000,          1, 0, 0, 0,       0));       // WAW pair
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  12'h000,          1, 1, 0, 32'h700, 0));
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  12'h000,          1, 1, 0, 32'h704, 0));
        vq.push_back(mkv(0, 1, 1, 1, Q0, Q1, 12'h000,          1, 1, 0, 32'h704, 0));       // count -> 2
        vq.push_back(mkv(0, 1, 1, 0, Q2, N,  12'h000,          1, 1, 0, 32'h704, 0));       // count -> 3
        vq.push_back(mkv(1, 1, 1, 1, Z0, Z1, 12'h000,          0, 0, 0, 0,       0));       // flush beats stall
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  12'h000,          1, 0, 0, 0,       0));       // nothing left
        vq.push_back(mkv(0, 0, 0, 0, N,  N,  12'h000,          1, 0, 0, 0,       0));

        // Power-on reset.
        drive(0, 0, 0, 0, N, N, 12'h000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_iss_valid0", 64'(bus.iss_valid0), 64'(0));
        chk("rst_iss_valid1", 64'(bus.iss_valid1), 64'(0));
        chk("rst_iss_info0",  64'(bus.iss_info0),  64'(0));
        chk("rst_iss_info1",  64'(bus.iss_info1),  64'(0));
        chk("rst_in_ready",   64'(bus.in_ready),   64'(1));
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[k]) begin
            @(negedge clk);
            drive(vq[k].fl, vq[k].st, vq[k].v0, vq[k].v1, vq[k].i0, vq[k].i1, vq[k].ex);
            #1;
            chk($sformatf("v%0d in_ready", k), 64'(bus.in_ready), 64'(vq[k].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d iss_valid0", k), 64'(bus.iss_valid0), 64'(vq[k].iv0));
            chk($sformatf("v%0d iss_valid1", k), 64'(bus.iss_valid1), 64'(vq[k].iv1));
            if (vq[k].iv0)
                chk($sformatf("v%0d pc0", k), 64'(bus.iss_info0[PC_LSB +: PC_W]), 64'(vq[k].pc0));
            if (vq[k].iv1)
                chk($sformatf("v%0d pc1", k), 64'(bus.iss_info1[PC_LSB +: PC_W]), 64'(vq[k].pc1));
        end

        // Mid-operation reset: issue slots and info clear, buffered pair lost.
        @(negedge clk);
        drive(0, 0, 1, 1, K0, K1, 12'h000);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 1, 1, K2, K3, 12'h000);
        #1;
        chk("mr_in_ready_pre", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        chk("mr_iss_valid0", 64'(bus.iss_valid0), 64'(1));
        chk("mr_iss_valid1", 64'(bus.iss_valid1), 64'(1));
        chk("mr_iss_info0",  64'(bus.iss_info0),  64'(K0));
        chk("mr_iss_info1",  64'(bus.iss_info1),  64'(K1));
        @(negedge clk);
        drive(0, 0, 0, 0, N, N, 12'h000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_rst_valid0", 64'(bus.iss_valid0), 64'(0));
        chk("mr_rst_valid1", 64'(bus.iss_valid1), 64'(0));
        chk("mr_rst_info0",  64'(bus.iss_info0),  64'(0));
        chk("mr_rst_info1",  64'(bus.iss_info1),  64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_in_ready_post", 64'(bus.in_ready), 64'(1));
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("mr_drained_valid0", 64'(bus.iss_valid0), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
